fifo_burst_writer: RTL and testbench

Read-side drain engine for the sync FIFO that buffers camera pixels ahead of frame memory. It watches the FIFO half flag, pops exactly BURST_LEN words per burst from the show-ahead read port, and issues them as Avalon-MM write bursts at incrementing addresses from a frame base. Frame boundaries come from a frame_start pulse. Address wraps to base after FRAME_WORDS words.

---
 rtl/fifo_burst_writer_if.sv | 38 +++
 rtl/fifo_burst_writer.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_burst_writer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_writer_if.sv
// ---------------------------------------------------------------------------
// fifo_burst_writer_if
// Bundles the two buses of the FIFO drain engine:
//   - FIFO read side : fifo_empty, fifo_half, fifo_read_data (into the engine),
//                      fifo_read, fifo_flush (out of the engine)
//   - Avalon-MM write: av_address, av_write, av_writedata, av_burstcount
//                      (out of the engine), av_waitrequest (into the engine)
// master modport = the burst writer, slave modport = FIFO + Avalon slave side.
// ---------------------------------------------------------------------------
interface fifo_burst_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) ();
    localparam int BC_WIDTH = $clog2(BURST_LEN) + 1;

    logic                  fifo_empty;
    logic                  fifo_half;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  fifo_flush;

    logic [ADDR_WIDTH-1:0] av_address;
    logic                  av_write;
    logic [DATA_WIDTH-1:0] av_writedata;
    logic [BC_WIDTH-1:0]   av_burstcount;
    logic                  av_waitrequest;

    modport master (
        input  fifo_empty, fifo_half, fifo_read_data, av_waitrequest,
        output fifo_read, fifo_flush, av_address, av_write, av_writedata, av_burstcount
    );

    modport slave (
        output fifo_empty, fifo_half, fifo_read_data, av_waitrequest,
        input  fifo_read, fifo_flush, av_address, av_write, av_writedata, av_burstcount
    );
endinterface

// File: rtl/fifo_burst_writer.sv
// ---------------------------------------------------------------------------
// fifo_burst_writer
// Drains the camera pixel FIFO into frame memory. Whenever the FIFO holds at
// least half its depth (BURST_LEN words) it pops exactly BURST_LEN words from
// the show-ahead read port and issues them as one Avalon-MM write burst.
// Burst addresses increment from the frame base and wrap back to it after
// FRAME_WORDS words, at which point frame_done pulses and the engine waits
// for the next frame_start.
//
// Ports:
//   clk          clock
//   rest         synchronous reset, active-high
//   enable       1 = run, 0 = stop after the current burst
//   base_addr    frame base byte address, loaded on frame_start
//   frame_start  one-cycle frame start pulse (re-syncs address and flushes FIFO)
//   frame_done   one-cycle pulse the cycle after the last beat of a frame
//   busy         1 whenever the engine is not idle
//   underflow    sticky: a beat completed while the FIFO reported empty
//   bus          FIFO read port + Avalon-MM write master (master modport)
// ---------------------------------------------------------------------------
module fifo_burst_writer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 153600
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  frame_start,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  underflow,
    fifo_burst_writer_if.master   bus
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int WORD_W = $clog2(FRAME_WORDS + 1);
    localparam int BC_W   = $clog2(BURST_LEN) + 1;

    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
    localparam logic [WORD_W-1:0]     WORD_STEP = WORD_W'(BURST_LEN);
    localparam logic [WORD_W-1:0]     WORD_LAST = WORD_W'(FRAME_WORDS);
    // One burst covers BURST_LEN words of DATA_WIDTH/8 bytes each.
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [BC_W-1:0]       BURST_CNT = BC_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH-1:0]   addr_s;
    logic [WORD_W-1:0]       word_cnt_r;
    logic [WORD_W-1:0]       word_cnt_s;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [BEAT_W-1:0]       beat_cnt_s;
    logic                    underflow_r;
    logic                    underflow_s;
    logic                    frame_done_r;
    logic                    frame_done_s;
    logic                    flush_s;
    logic                    beat_s;
    logic                    in_burst_s;

    // Next-state, counter and strobe logic of the drain FSM
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        word_cnt_s   = word_cnt_r;
        beat_cnt_s   = beat_cnt_r;
        underflow_s  = underflow_r;
        frame_done_s = 1'b0;
        flush_s      = 1'b0;
        beat_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ARM: begin
                // A frame start wins over a simultaneous disable so a
                // frame boundary is never lost.
                if (frame_start) begin
                    addr_s     = base_addr;
                    word_cnt_s = '0;
                    flush_s    = 1'b1;
                    state_s    = ST_WAIT;
                end else if (!enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ARM;
                end
            end

            ST_WAIT: begin
                if (frame_start) begin
                    addr_s     = base_addr;
                    word_cnt_s = '0;
                    flush_s    = 1'b1;
                    state_s    = ST_WAIT;
                end else if (!enable) begin
                    state_s = ST_IDLE;
                end else if (bus.fifo_half) begin
                    beat_cnt_s = '0;
                    state_s    = ST_BURST;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            ST_BURST: begin
                // frame_start is deliberately ignored here: a burst is never
                // aborted once the slave has seen its first beat request.
                beat_s = !bus.av_waitrequest;
                if (beat_s) begin
                    if (bus.fifo_empty) begin
                        underflow_s = 1'b1;
                    end else begin
                        underflow_s = underflow_r;
                    end

                    if (beat_cnt_r == BEAT_LAST) begin
                        beat_cnt_s = '0;
                        if ((word_cnt_r + WORD_STEP) == WORD_LAST) begin
                            frame_done_s = 1'b1;
                            addr_s       = base_addr;
                            word_cnt_s   = '0;
                            state_s      = ST_ARM;
                        end else begin
                            word_cnt_s = word_cnt_r + WORD_STEP;
                            addr_s     = addr_r + ADDR_STEP;
                            if (!enable) begin
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_WAIT;
                            end
                        end
                    end else begin
                        beat_cnt_s = beat_cnt_r + BEAT_ONE;
                        state_s    = ST_BURST;
                    end
                end else begin
                    beat_cnt_s = beat_cnt_r;
                    state_s    = ST_BURST;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rest) begin
            state_r      <= ST_IDLE;
            addr_r       <= '0;
            word_cnt_r   <= '0;
            beat_cnt_r   <= '0;
            underflow_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            addr_r       <= addr_s;
            word_cnt_r   <= word_cnt_s;
            beat_cnt_r   <= beat_cnt_s;
            underflow_r  <= underflow_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign in_burst_s = (state_r == ST_BURST);

    // Bus outputs are forced to zero outside a burst; write data follows the
    // show-ahead FIFO head combinationally so each pop lines up with its beat.
    assign bus.av_write      = in_burst_s;
    assign bus.av_address    = in_burst_s ? addr_r : '0;
    assign bus.av_burstcount = in_burst_s ? BURST_CNT : '0;
    assign bus.av_writedata  = in_burst_s ? bus.fifo_read_data : '0;
    assign bus.fifo_read     = beat_s;
    assign bus.fifo_flush    = flush_s;

    assign busy       = (state_r != ST_IDLE);
    assign frame_done = frame_done_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_writer
// Directed bench for fifo_burst_writer with BURST_LEN=4, FRAME_WORDS=8,
// a show-ahead FIFO model of depth 8, and a transaction-level reference model
// (word queue + per-frame beat count) checked every cycle.
// ---------------------------------------------------------------------------
module tb_fifo_burst_writer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int FW = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rest;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic          frame_start;
    logic          frame_done;
    logic          busy;
    logic          underflow;

    logic          push_req    = 1'b0;
    logic [DW-1:0] push_data   = '0;
    logic          force_empty = 1'b0;

    fifo_burst_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus ();

    fifo_burst_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .FRAME_WORDS(FW)
    ) dut (
        .clk(clk), .rest(rest), .enable(enable), .base_addr(base_addr),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
        .underflow(underflow), .bus(bus)
    );

    // Show-ahead FIFO, depth 8
    logic [DW-1:0] fmem [8];
    logic [2:0]    frd  = 3'd0;
    logic [2:0]    fwr  = 3'd0;
    logic [3:0]    fcnt = 4'd0;
    logic          do_push;
    logic          do_pop;
    assign do_push = push_req && (fcnt < 4'd8);
    assign do_pop  = bus.fifo_read && (fcnt != 4'd0);

    always @(posedge clk) begin
        if (bus.fifo_flush) begin
            frd  <= 3'd0;
            fwr  <= 3'd0;
            fcnt <= 4'd0;
        end else begin
            if (do_push) fmem[fwr] <= push_data;
            fwr  <= fwr + {2'b00, do_push};
            frd  <= frd + {2'b00, do_pop};
            fcnt <= fcnt + {3'b000, do_push} - {3'b000, do_pop};
        end
    end

    assign bus.fifo_empty     = (fcnt == 4'd0) || force_empty;
    assign bus.fifo_half      = (fcnt >= 4'd4);
    assign bus.fifo_read_data = (fcnt == 4'd0) ? '0 : fmem[frd];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words pushed since the last flush, beats done in frame
    logic [DW-1:0] sb [$];
    int            m_frame_beats = 0;
    logic          exp_done = 1'b0;
    logic          exp_uf   = 1'b0;
    logic          model_on = 1'b0;

    initial begin : compare_proc
        logic          m_beat;
        logic          m_done_next;
        logic [31:0]   m_addr;
        logic [DW-1:0] m_data;
        forever begin
            @(negedge clk);
            #2;
            if (model_on) begin
                m_beat      = bus.av_write && !bus.av_waitrequest;
                m_done_next = 1'b0;
                chk("read_strobe", bus.fifo_read, m_beat);
                chk("frame_done", frame_done, exp_done);
                chk("underflow", underflow, exp_uf);
                if (bus.fifo_read) begin
                    chk("flush_with_read", bus.fifo_flush, 1'b0);
                    chk("done_with_read", frame_done, 1'b0);
                end
                if (m_beat) begin
                    m_addr = BASE + 32'(m_frame_beats / BL) * 32'(BL * (DW / 8));
                    m_data = (sb.size() > 0) ? sb.pop_front() : '0;
                    chk("beat_addr", bus.av_address, m_addr);
                    chk("beat_burstcount", bus.av_burstcount, 64'd4);
                    chk("beat_data", bus.av_writedata, m_data);
                    if (bus.fifo_empty) exp_uf = 1'b1;
                    m_frame_beats++;
                    if (m_frame_beats == FW) begin
                        m_frame_beats = 0;
                        m_done_next   = 1'b1;
                    end
                end
                if (bus.fifo_flush) begin
                    sb.delete();
                    m_frame_beats = 0;
                end
                if (rest) begin
                    exp_uf      = 1'b0;
                    m_done_next = 1'b0;
                end
                exp_done = m_done_next;
            end
        end
    end

    task automatic push_words(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            push_req  = 1'b1;
            push_data = first + DW'(i);
            sb.push_back(first + DW'(i));
            @(negedge clk);
        end
        push_req = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        #1;
        chk("flush_on_frame_start", bus.fifo_flush, 1'b1);
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        chk("flush_one_cycle", bus.fifo_flush, 1'b0);
    endtask

    // Follows one burst; drives per-cycle stall/disable/frame_start/force-empty/reset
    task automatic measure(input logic [63:0] stall_mask, input int en_off_at, input int fs_at,
                           input int uf_at, input int rst_at,
                           output int cycles, output int pops,
                           output logic [31:0] first_addr, output logic [31:0] first_data);
        int            k = 0;
        int            guard = 0;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_d = '0;
        cycles = 0; pops = 0; first_addr = '0; first_data = '0;
        while (!bus.av_write && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.av_write) begin
            chk("burst_start_timeout", 1'b0, 1'b1);
            return;
        end
        while (bus.av_write && k < 64) begin
            bus.av_waitrequest = stall_mask[k];
            if (k == en_off_at) enable = 1'b0;
            frame_start = (k == fs_at);
            force_empty = (k == uf_at);
            if (k == rst_at) rest = 1'b1;
            #1;
            if (k == 0) first_addr = bus.av_address;
            else chk("addr_hold", bus.av_address, first_addr);
            chk("no_flush_in_burst", bus.fifo_flush, 1'b0);
            if (prev_stall) chk("data_hold", bus.av_writedata, prev_d);
            if (bus.fifo_read) begin
                pops++;
                if (pops == 1) first_data = bus.av_writedata;
            end
            prev_stall = !bus.fifo_read;
            prev_d     = bus.av_writedata;
            cycles++;
            k++;
            @(negedge clk);
        end
        bus.av_waitrequest = 1'b0;
        frame_start        = 1'b0;
        force_empty        = 1'b0;
        rest               = 1'b0;
    endtask

    int          r_cyc, r_pops, r2_cyc, r2_pops;
    logic [31:0] r_addr, r_data, r2_addr, r2_data;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rest = 1'b1; enable = 1'b0; frame_start = 1'b0; base_addr = BASE;
        bus.av_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_av_write", bus.av_write, 1'b0);
        chk("rst_fifo_read", bus.fifo_read, 1'b0);
        chk("rst_flush", bus.fifo_flush, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_av_address", bus.av_address, 64'd0);
        chk("rst_burstcount", bus.av_burstcount, 64'd0);
        model_on = 1'b1;
        rest = 1'b0;
        @(negedge clk);

        // 1: single burst, no stall
        enable = 1'b1;
        @(negedge clk);
        chk("arm_busy", busy, 1'b1);
        pulse_frame_start();
        push_words(32'hA0A0_0000, 4);
        chk("latency_wait_cycle", bus.av_write, 1'b0);
        @(negedge clk);
        chk("latency_write_next", bus.av_write, 1'b1);
        measure(64'h0, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t1_cycles", r_cyc, 64'd4);
        chk("t1_pops", r_pops, 64'd4);
        chk("t1_addr", r_addr, 64'h1000);
        chk("t1_data0", r_data, 64'hA0A0_0000);

        // 2: waitrequest stalls on beats 1 and 2, three cycles each
        pulse_frame_start();
        push_words(32'hB0B0_0000, 4);
        measure(64'h00EE, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t2_cycles", r_cyc, 64'd10);
        chk("t2_pops", r_pops, 64'd4);
        chk("t2_addr", r_addr, 64'h1000);

        // 3: eight words pushed continuously -> two bursts, frame wrap
        pulse_frame_start();
        fork
            push_words(32'hC0C0_0000, 8);
            begin
                measure(64'h0, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
                measure(64'h0, -1, -1, -1, -1, r2_cyc, r2_pops, r2_addr, r2_data);
            end
        join
        chk("t3_addr0", r_addr, 64'h1000);
        chk("t3_addr1", r2_addr, 64'h1010);
        chk("t3_data4", r2_data, 64'hC0C0_0004);
        chk("t3_cycles1", r2_cyc, 64'd4);
        chk("t3_frame_done", frame_done, 1'b1);
        chk("t3_busy_arm", busy, 1'b1);
        @(negedge clk);
        chk("t3_frame_done_pulse", frame_done, 1'b0);
        push_words(32'hD0D0_0000, 4);
        repeat (3) begin
            @(negedge clk);
            chk("t3_arm_ignores_half", bus.av_write, 1'b0);
        end
        pulse_frame_start();
        push_words(32'hE0E0_0000, 4);
        measure(64'h0, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t3_new_frame_addr", r_addr, 64'h1000);
        chk("t3_flushed_data", r_data, 64'hE0E0_0000);

        // 4: disable during beat 1, frame_start during beat 2
        pulse_frame_start();
        push_words(32'hF0F0_0000, 4);
        measure(64'h0, 1, 2, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t4_cycles", r_cyc, 64'd4);
        chk("t4_pops", r_pops, 64'd4);
        chk("t4_busy_idle", busy, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        chk("t4_rearm_busy", busy, 1'b1);
        pulse_frame_start();

        // 5: forced empty on beat 3 -> sticky underflow
        push_words(32'h1111_0000, 4);
        measure(64'h0, -1, -1, 3, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t5_underflow_set", underflow, 1'b1);
        push_words(32'h2222_0000, 4);
        measure(64'h0, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t5_second_addr", r_addr, 64'h1010);
        chk("t5_frame_done", frame_done, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("t5_underflow_sticky", underflow, 1'b1);
        end

        // 6: reset during beat 2
        pulse_frame_start();
        push_words(32'h3333_0000, 4);
        measure(64'h0, -1, -1, -1, 2, r_cyc, r_pops, r_addr, r_data);
        chk("t6_cycles", r_cyc, 64'd3);
        chk("t6_pops", r_pops, 64'd3);
        chk("t6_av_write", bus.av_write, 1'b0);
        chk("t6_fifo_read", bus.fifo_read, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_underflow_clr", underflow, 1'b0);
        chk("t6_av_address", bus.av_address, 64'd0);
        @(negedge clk);
        chk("t6_arm_busy", busy, 1'b1);
        push_words(32'h4444_0000, 3);
        repeat (3) begin
            @(negedge clk);
            chk("t6_needs_frame_start", bus.av_write, 1'b0);
        end
        pulse_frame_start();
        push_words(32'h5555_0000, 4);
        measure(64'h0, -1, -1, -1, -1, r_cyc, r_pops, r_addr, r_data);
        chk("t6_post_addr", r_addr, 64'h1000);
        chk("t6_post_data", r_data, 64'h5555_0000);
        chk("t6_post_cycles", r_cyc, 64'd4);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
